// File: rtl/fir_out_decim_fifo.sv
// Output stage behind fir_16tap: drops pipeline warm-up samples, block-averages by DECIM,
// and buffers the decimated stream in a first-word-fall-through FIFO with a sticky drop flag.
module fir_out_decim_fifo #(
  parameter int W     = 16,
  parameter int DECIM = 4,
  parameter int SKIP  = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [W-1:0]       y_in,
  input  logic                      in_en,
  output logic signed [W-1:0]       m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  localparam int LG  = $clog2(DECIM);
  localparam int AW  = W + LG;
  localparam int PHW = (LG > 0) ? LG : 1;
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;

  logic [SKW-1:0]         r_skip;
  logic [PHW-1:0]         r_phase;
  logic signed [AW-1:0]   r_acc;
  logic signed [W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   r_valid;
  logic                   r_ovf;

  logic                   w_used;
  logic                   w_last;
  logic signed [AW-1:0]   w_ext;
  logic signed [AW-1:0]   w_base;
  logic signed [AW-1:0]   w_sum;
  logic signed [W-1:0]    w_res;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_accept;
  logic                   w_drop;
  logic [LW-1:0]          w_level_nxt;

  // Group arithmetic: the sum never overflows AW bits, so the shifted mean always fits in W bits.
  always_comb begin
    w_used = in_en & (r_skip == SKW'(SKIP));
    w_last = (r_phase == PHW'(DECIM - 1));
    w_ext  = AW'(y_in);
    if (r_phase == {PHW{1'b0}}) begin
      w_base = {AW{1'b0}};
    end else begin
      w_base = r_acc;
    end
    w_sum  = w_base + w_ext;
    w_res  = W'(w_sum >>> LG);
  end

  // FIFO handshake: a full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    w_push   = w_used & w_last;
    w_pop    = r_valid & m_ready;
    w_full   = (r_level == LW'(DEPTH));
    w_accept = w_push & (~w_full | w_pop);
    w_drop   = w_push & ~w_accept;
    case ({w_accept, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Warm-up discard, phase and accumulator advance only on enabled samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skip  <= {SKW{1'b0}};
      r_phase <= {PHW{1'b0}};
      r_acc   <= {AW{1'b0}};
    end else if (in_en) begin
      if (!w_used) begin
        r_skip <= r_skip + SKW'(1);
      end else begin
        r_acc <= w_sum;
        if (w_last) begin
          r_phase <= {PHW{1'b0}};
        end else begin
          r_phase <= r_phase + PHW'(1);
        end
      end
    end
  end

  // Storage and pointers; entries are cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_res;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy, valid and sticky drop flag; a drop beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= {LW{1'b0}};
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != {LW{1'b0}});
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign m_data   = r_mem[r_rd_ptr];
  assign m_valid  = r_valid;
  assign level    = r_level;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_fir_out_decim_fifo.sv
// Directed plus randomized bench for fir_out_decim_fifo against a queue-based reference model.
module tb_fir_out_decim_fifo;

  localparam int W     = 16;
  localparam int DECIM = 4;
  localparam int SKIP  = 8;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [W-1:0]  y_in = '0;
  logic                 in_en = 1'b0;
  logic                 m_ready = 1'b0;
  logic                 clr_ovf = 1'b0;
  logic signed [W-1:0]  m_data;
  logic                 m_valid;
  logic [LW-1:0]        level;
  logic                 overflow;

  int checks = 0;
  int errors = 0;

  int mq[$];
  int m_skip = 0;
  int m_cnt  = 0;
  int m_sum  = 0;
  bit m_ovf  = 1'b0;

  fir_out_decim_fifo #(.W(W), .DECIM(DECIM), .SKIP(SKIP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .in_en(in_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_mean(input int s);
    int q;
    q = s / DECIM;
    if ((s % DECIM) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, 32'(m_valid), 32'(mq.size() != 0));
    chk({tag, "_level"}, 32'(level), 32'(mq.size()));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) chk({tag, "_data"}, 32'(m_data), mq[0]);
  endtask

  task automatic step(input bit en, input logic signed [W-1:0] y, input bit rdy, input bit clr);
    bit pop, push, full;
    int res;
    @(negedge clk);
    in_en = en; y_in = y; m_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    pop = rdy && (mq.size() != 0);
    push = 1'b0;
    res = 0;
    if (en) begin
      if (m_skip < SKIP) m_skip++;
      else begin
        m_sum += int'(y);
        m_cnt++;
        if (m_cnt == DECIM) begin
          push = 1'b1; res = floor_mean(m_sum); m_sum = 0; m_cnt = 0;
        end
      end
    end
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (push && full && !pop) m_ovf = 1'b1;
    else begin
      if (push) mq.push_back(res);
      if (clr) m_ovf = 1'b0;
    end
    #1;
    check_state("step");
  endtask

  task automatic rnd_sample(output logic signed [W-1:0] v);
    v = W'($urandom);
  endtask

  task automatic feed_group(input bit rdy_last);
    logic signed [W-1:0] v;
    for (int i = 0; i < DECIM; i++) begin
      rnd_sample(v);
      step(1'b1, v, rdy_last && (i == DECIM - 1), 1'b0);
    end
  endtask

  task automatic skip_warmup();
    logic signed [W-1:0] v;
    for (int i = 0; i < SKIP; i++) begin
      rnd_sample(v);
      step(1'b1, v, 1'b0, 1'b0);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    mq.delete(); m_skip = 0; m_cnt = 0; m_sum = 0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic signed [W-1:0] v;
    #1 rst = 1'b0;
    #1;
    chk("init_valid", 32'(m_valid), 32'd0);
    chk("init_level", 32'(level), 32'd0);
    chk("init_ovf", 32'(overflow), 32'd0);
    chk("init_data", 32'(m_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Skip and average
    for (int i = 0; i < SKIP; i++) step(1'b1, 16'sd100, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    chk("t2_not_yet", 32'(m_valid), 32'd0);
    step(1'b1, 16'sd4, 1'b0, 1'b0);
    chk("t2_first", 32'(m_data), 32'sd2);
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_level", 32'(level), 32'd1);

    // Negative floor and positive full scale
    for (int i = 1; i <= 4; i++) step(1'b1, -16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'sd32767, 1'b0, 1'b0);
    chk("t3_level", 32'(level), 32'd3);
    chk("t3_head", 32'(m_data), 32'sd2);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("t3_neg", 32'(m_data), -32'sd3);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("t3_max", 32'(m_data), 32'sd32767);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("t3_empty", 32'(m_valid), 32'd0);

    // Async reset with level 3 while the stream runs
    for (int g = 0; g < 3; g++) feed_group(1'b0);
    chk("t1_pre_level", 32'(level), 32'd3);
    async_reset();

    // Overflow after nine groups, then drain and clear
    skip_warmup();
    for (int g = 0; g < 9; g++) feed_group(1'b0);
    chk("t4_level", 32'(level), 32'd8);
    chk("t4_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("t4_drained", 32'(level), 32'd0);
    chk("t4_sticky", 32'(overflow), 32'd1);
    step(1'b0, 16'sd0, 1'b0, 1'b1);
    chk("t4_cleared", 32'(overflow), 32'd0);

    // Full FIFO with push and pop in the same cycle
    for (int g = 0; g < 8; g++) feed_group(1'b0);
    feed_group(1'b1);
    chk("t5_level", 32'(level), 32'd8);
    chk("t5_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 16'sd0, 1'b1, 1'b0);

    // Enable gaps, including during warm-up
    async_reset();
    for (int i = 0; i < SKIP; i++) begin
      step(1'b1, 16'sd100, 1'b0, 1'b0);
      for (int j = 0; j < 3; j++) begin rnd_sample(v); step(1'b0, v, 1'b0, 1'b0); end
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 3) chk("t6_not_yet", 32'(m_valid), 32'd0);
      if (i == 4) begin
        chk("t6_first", 32'(m_data), 32'sd2);
        chk("t6_valid", 32'(m_valid), 32'd1);
      end
      for (int j = 0; j < 3; j++) begin rnd_sample(v); step(1'b0, v, 1'b0, 1'b0); end
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rnd_sample(v);
      step(($urandom % 4) != 0, v, ($urandom % 3) == 0, ($urandom % 16) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
